// File: rtl/spi_flash_byte_reader_pkg.sv
// spi_flash_byte_reader_pkg: shared constants and state encoding for the SPI flash byte reader.
package spi_flash_byte_reader_pkg;
    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int CMD_BITS = 32;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        DATA    = 3'd2,
        STALL   = 3'd3,
        CS_WAIT = 3'd4
    } state_t;
endpackage

// File: rtl/spi_flash_byte_reader_sck_gen.sv
// spi_sck_gen: mode-0 SCK divider with rise/fall ticks; disabling it parks SCK low and restarts the count.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt_q;
    logic          sck_q;
    logic          wrap;
    assign wrap   = en_i && cnt_q == CW'(CLK_DIV - 1);
    assign rise_o = wrap & ~sck_q;
    assign fall_o = wrap & sck_q;
    assign sck_o  = sck_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            sck_q <= sck_q ^ wrap;
        end
    end
endmodule

// File: rtl/spi_flash_byte_reader.sv
// spi_flash_byte_reader: issues SPI READ (0x03) and streams flash bytes with ready-driven SCK stalls.
module spi_flash_byte_reader
    import spi_flash_byte_reader_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int ADDR_W      = 24,
    parameter int CS_HIGH_MIN = 4
) (
    input  logic              i_sysclk,
    input  logic              i_arst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_stop,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_byte_en,
    output logic [7:0]        o_byte,
    output logic              o_spi_cs_n,
    output logic              o_spi_sck,
    output logic              o_spi_mosi,
    input  logic              i_spi_miso
);
    localparam int WW = $clog2(CS_HIGH_MIN + 1);
    state_t          state_q;
    logic [30:0]     sr_q;
    logic [5:0]      bit_q;
    logic [6:0]      rx_q;
    logic [WW-1:0]   wait_q;
    logic [7:0]      byte_q;
    logic            stop_q, busy_q, byte_en_q, cs_n_q, mosi_q;
    logic            rise, fall, stop_hit, close;
    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk_i  (i_sysclk),
        .rst_i  (i_arst),
        .en_i   (state_q == CMD || state_q == DATA),
        .sck_o  (o_spi_sck),
        .rise_o (rise),
        .fall_o (fall)
    );
    // A stop seen mid-byte is held until the next byte boundary (or fall tick in CMD).
    assign stop_hit = i_stop | stop_q;
    assign close    = stop_hit && ((state_q == CMD && fall) ||
                                   (state_q == DATA && fall && bit_q == 6'd0) ||
                                   state_q == STALL);
    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_q     <= '0;
            rx_q      <= '0;
            wait_q    <= '0;
            byte_q    <= 8'h00;
            stop_q    <= 1'b0;
            busy_q    <= 1'b0;
            byte_en_q <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            byte_en_q <= 1'b0;
            if (close) begin
                state_q <= CS_WAIT;
                cs_n_q  <= 1'b1;
                mosi_q  <= 1'b0;
                wait_q  <= '0;
                stop_q  <= 1'b0;
            end else begin
                if (i_stop && state_q != IDLE && state_q != CS_WAIT) stop_q <= 1'b1;
                case (state_q)
                    IDLE: if (i_start) begin
                        {mosi_q, sr_q} <= {SPI_CMD_READ, i_addr};
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                        stop_q  <= 1'b0;
                        state_q <= CMD;
                    end
                    CMD: if (fall) begin
                        {mosi_q, sr_q} <= {sr_q, 1'b0};
                        bit_q   <= bit_q == 6'(CMD_BITS - 1) ? 6'd0 : bit_q + 6'd1;
                        state_q <= bit_q == 6'(CMD_BITS - 1) ? DATA : CMD;
                    end
                    DATA: if (rise) begin
                        rx_q  <= {rx_q[5:0], i_spi_miso};
                        bit_q <= bit_q == 6'd7 ? 6'd0 : bit_q + 6'd1;
                        if (bit_q == 6'd7) begin
                            byte_q    <= {rx_q, i_spi_miso};
                            byte_en_q <= 1'b1;
                        end
                    end else if (fall && bit_q == 6'd0 && !i_ready) begin
                        state_q <= STALL;
                    end
                    STALL: if (i_ready) state_q <= DATA;
                    CS_WAIT: if (wait_q == WW'(CS_HIGH_MIN - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign o_busy     = busy_q;
    assign o_byte_en  = byte_en_q;
    assign o_byte     = byte_q;
    assign o_spi_cs_n = cs_n_q;
    assign o_spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_flash_byte_reader.sv
// tb_spi_flash_byte_reader: random-address reads against a behavioural SPI flash and byte-stream model.
module tb_spi_flash_byte_reader;
    localparam int CLK_DIV     = 2;
    localparam int CS_HIGH_MIN = 4;
    localparam int BYTE_CYC    = 16 * CLK_DIV;
    logic        i_sysclk = 1'b0, i_arst = 1'b1, i_start = 1'b0, i_stop = 1'b0, i_ready = 1'b1;
    logic [23:0] i_addr = '0;
    logic        o_busy, o_byte_en, o_spi_cs_n, o_spi_sck, o_spi_mosi;
    logic        i_spi_miso = 1'b0;
    logic [7:0]  o_byte;
    int          npass = 0, nchk = 0, cyc = 0;
    logic [7:0]  mem [256];
    logic [7:0]  got [$];
    int          gt [$];
    int          nbits = 0, dbit = 0, rises = 0;
    logic [31:0] cmd_word = '0;
    logic [7:0]  fb;

    spi_flash_byte_reader #(.CLK_DIV(CLK_DIV), .ADDR_W(24), .CS_HIGH_MIN(CS_HIGH_MIN)) dut (
        .i_sysclk(i_sysclk), .i_arst(i_arst), .i_start(i_start), .i_addr(i_addr),
        .i_stop(i_stop), .i_ready(i_ready), .o_busy(o_busy), .o_byte_en(o_byte_en),
        .o_byte(o_byte), .o_spi_cs_n(o_spi_cs_n), .o_spi_sck(o_spi_sck),
        .o_spi_mosi(o_spi_mosi), .i_spi_miso(i_spi_miso)
    );

    always #5 i_sysclk = ~i_sysclk;

    always @(negedge i_sysclk) begin
        cyc++;
        if (o_byte_en) begin
            got.push_back(o_byte);
            gt.push_back(cyc);
        end
    end

    // Flash: 32 command bits captured on SCK rise, data bits driven on SCK fall from mem[addr+n].
    always @(o_spi_sck or o_spi_cs_n) begin
        if (o_spi_cs_n) begin
            nbits = 0;
            dbit = 0;
            rises = 0;
            i_spi_miso = 1'b0;
        end else if (o_spi_sck) begin
            rises++;
            if (nbits < 32) begin
                cmd_word = {cmd_word[30:0], o_spi_mosi};
                nbits++;
            end
        end else if (nbits == 32) begin
            fb = mem[8'(cmd_word[7:0] + 8'(dbit / 8))];
            i_spi_miso = fb[7 - (dbit % 8)];
            dbit++;
        end
    end

    task automatic wait_got(input int target, input int budget);
        for (int i = 0; i < budget && got.size() < target; i++) begin
            @(negedge i_sysclk); #1;
        end
    endtask

    task automatic start_xfer(input logic [23:0] a);
        @(negedge i_sysclk); #1;
        i_addr = a;
        i_start = 1'b1;
        @(negedge i_sysclk); #1;
        i_start = 1'b0;
    endtask

    task automatic pulse_stop;
        i_stop = 1'b1;
        @(negedge i_sysclk); #1;
        i_stop = 1'b0;
    endtask

    task automatic cs_wait_len(output int n, input bit poke);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_sysclk); #1;
            if (!o_busy) break;
            if (o_spi_cs_n) n++;
            if (poke) i_start = (n == 2);
        end
        i_start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge i_sysclk);
        #1;
        nchk++;
        if ({o_busy, o_byte_en, o_byte, o_spi_cs_n, o_spi_sck, o_spi_mosi} !== {2'b00, 8'h00, 3'b100})
            $display("FAIL reset_state: got %b want %b",
                     {o_busy, o_byte_en, o_byte, o_spi_cs_n, o_spi_sck, o_spi_mosi}, {2'b00, 8'h00, 3'b100});
        else npass++;
        i_arst = 1'b0;
        @(negedge i_sysclk);
    endtask

    task automatic test_cmd_stream;
        logic [23:0] a = 24'h012345;
        int base = got.size();
        int n;
        mem[8'h45] = 8'hFF; mem[8'h46] = 8'hD8; mem[8'h47] = 8'hFF; mem[8'h48] = 8'hE0;
        start_xfer(a);
        nchk++;
        if ({o_spi_cs_n, o_busy} !== 2'b01) $display("FAIL cs_after_start: got %b want 01", {o_spi_cs_n, o_busy});
        else npass++;
        wait_got(base + 1, 400);
        nchk++;
        if (rises !== 40) $display("FAIL sck_before_byte0: got %0d want 40", rises);
        else npass++;
        nchk++;
        if ({nbits, cmd_word} !== {32'd32, 8'h03, a})
            $display("FAIL cmd_word: got %0d/%h want 32/%h", nbits, cmd_word, {8'h03, a});
        else npass++;
        wait_got(base + 4, 400);
        pulse_stop();
        cs_wait_len(n, 1'b0);
        nchk++;
        if (got.size() !== base + 4) $display("FAIL stream_count: got %0d want 4", got.size() - base);
        else npass++;
        for (int k = 0; k < 4 && got.size() >= base + 4; k++) begin
            nchk++;
            if (got[base + k] !== mem[8'(8'h45 + k)]) $display("FAIL stream_byte%0d: got %h want %h", k, got[base + k], mem[8'(8'h45 + k)]);
            else npass++;
            if (k > 0) begin
                nchk++;
                if (gt[base + k] - gt[base + k - 1] !== BYTE_CYC)
                    $display("FAIL stream_gap%0d: got %0d want %0d", k, gt[base + k] - gt[base + k - 1], BYTE_CYC);
                else npass++;
            end
        end
    endtask

    task automatic test_stall;
        logic [23:0] a = 24'($urandom);
        int base = got.size();
        int bad = 0, t0, n;
        start_xfer(a);
        wait_got(base + 2, 600);
        i_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge i_sysclk); #1;
            if (i >= 2 && (o_spi_sck || o_spi_cs_n)) bad++;
        end
        nchk++;
        if (bad !== 0 || got.size() !== base + 2) $display("FAIL stall_hold: got bad=%0d bytes=%0d want 0/2", bad, got.size() - base);
        else npass++;
        i_ready = 1'b1;
        t0 = cyc;
        wait_got(base + 3, 200);
        pulse_stop();
        cs_wait_len(n, 1'b0);
        nchk++;
        if (got.size() !== base + 3) $display("FAIL stall_count: got %0d want 3", got.size() - base);
        else npass++;
        if (got.size() >= base + 3) begin
            nchk++;
            if (got[base + 2] !== mem[8'(a[7:0] + 8'd2)]) $display("FAIL stall_byte2: got %h want %h", got[base + 2], mem[8'(a[7:0] + 8'd2)]);
            else npass++;
            nchk++;
            if (gt[base + 2] - t0 < BYTE_CYC - 2 || gt[base + 2] - t0 > BYTE_CYC + 4)
                $display("FAIL stall_latency: got %0d want about %0d", gt[base + 2] - t0, BYTE_CYC);
            else npass++;
        end
    endtask

    task automatic test_stop;
        logic [23:0] a = 24'($urandom);
        int base = got.size();
        int n;
        start_xfer(a);
        wait_got(base + 2, 600);
        repeat (10) @(negedge i_sysclk);
        #1;
        pulse_stop();
        wait_got(base + 3, 200);
        cs_wait_len(n, 1'b1);
        nchk++;
        if (n !== CS_HIGH_MIN) $display("FAIL stop_cs_wait: got %0d want %0d", n, CS_HIGH_MIN);
        else npass++;
        repeat (10) @(negedge i_sysclk);
        #1;
        nchk++;
        if ({o_busy, o_spi_cs_n} !== 2'b01) $display("FAIL start_in_cs_wait: got %b want 01", {o_busy, o_spi_cs_n});
        else npass++;
        nchk++;
        if (got.size() !== base + 3) $display("FAIL stop_count: got %0d want 3", got.size() - base);
        else npass++;
        if (got.size() >= base + 3) begin
            nchk++;
            if (got[base + 2] !== mem[8'(a[7:0] + 8'd2)]) $display("FAIL stop_byte2: got %h want %h", got[base + 2], mem[8'(a[7:0] + 8'd2)]);
            else npass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] a = 24'($urandom);
        int base = got.size();
        int n;
        start_xfer(a);
        wait_got(base + 1, 600);
        repeat (12) @(negedge i_sysclk);
        i_arst = 1'b1;
        #1;
        nchk++;
        if ({o_busy, o_byte_en, o_spi_cs_n, o_spi_sck} !== 4'b0010)
            $display("FAIL reset_mid: got %b want 0010", {o_busy, o_byte_en, o_spi_cs_n, o_spi_sck});
        else npass++;
        repeat (3) @(negedge i_sysclk);
        i_arst = 1'b0;
        repeat (3) @(negedge i_sysclk);
        #1;
        nchk++;
        if (got.size() !== base + 1) $display("FAIL reset_no_strobe: got %0d want 1", got.size() - base);
        else npass++;
        a = 24'($urandom);
        base = got.size();
        start_xfer(a);
        wait_got(base + 1, 600);
        nchk++;
        if ({nbits, cmd_word} !== {32'd32, 8'h03, a})
            $display("FAIL reset_cmd: got %0d/%h want 32/%h", nbits, cmd_word, {8'h03, a});
        else npass++;
        nchk++;
        if (got.size() !== base + 1 || got[base] !== mem[a[7:0]]) $display("FAIL reset_byte0: got %h want %h", o_byte, mem[a[7:0]]);
        else npass++;
        pulse_stop();
        cs_wait_len(n, 1'b0);
    endtask

    task automatic test_cmd_stop;
        int base = got.size();
        int n;
        start_xfer(24'($urandom));
        repeat (20) @(negedge i_sysclk);
        #1;
        pulse_stop();
        cs_wait_len(n, 1'b0);
        nchk++;
        if (got.size() !== base) $display("FAIL cmd_stop_bytes: got %0d want 0", got.size() - base);
        else npass++;
        nchk++;
        if (n !== CS_HIGH_MIN) $display("FAIL cmd_stop_cs_wait: got %0d want %0d", n, CS_HIGH_MIN);
        else npass++;
    endtask

    task automatic test_random;
        for (int t = 0; t < 4; t++) begin
            logic [23:0] a = 24'($urandom);
            int nb = $urandom_range(2, 5);
            int base = got.size();
            int n;
            start_xfer(a);
            for (int k = 0; k < nb; k++) begin
                wait_got(base + k + 1, 400);
                if (k == nb - 1) pulse_stop();
                else if ($urandom_range(0, 1) == 1) begin
                    i_ready = 1'b0;
                    repeat ($urandom_range(3, 20)) @(negedge i_sysclk);
                    i_ready = 1'b1;
                end
            end
            cs_wait_len(n, 1'b0);
            nchk++;
            if (got.size() !== base + nb) $display("FAIL rand%0d_count: got %0d want %0d", t, got.size() - base, nb);
            else npass++;
            for (int k = 0; k < nb && got.size() >= base + nb; k++) begin
                nchk++;
                if (got[base + k] !== mem[8'(a[7:0] + 8'(k))])
                    $display("FAIL rand%0d_byte%0d: got %h want %h", t, k, got[base + k], mem[8'(a[7:0] + 8'(k))]);
                else npass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_cmd_stream();
        test_stall();
        test_stop();
        test_reset_mid();
        test_cmd_stop();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
